// File: rtl/m2w_xmit.sv
// M2W transmit end: formats Memory-stage results (load extract/extend) and
// hands them to Writeback through a 2-entry skid buffer with registered ready.
module m2w_xmit #(
    parameter int RSZ     = 32,
    parameter int GPR_ASZ = 5
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               cpu_halt,
    input  logic               mem_valid,
    output logic               mem_rdy,
    input  logic               mem_Rd_wr,
    input  logic [GPR_ASZ-1:0] mem_Rd_addr,
    input  logic [RSZ-1:0]     mem_Rd_data,
    input  logic               mem_is_ld,
    input  logic [1:0]         mem_ld_size,
    input  logic               mem_ld_unsigned,
    input  logic [1:0]         mem_byte_off,
    input  logic [RSZ-1:0]     mem_ld_data,
    output logic               m2w_valid,
    input  logic               m2w_rdy,
    output logic               m2w_Rd_wr,
    output logic [GPR_ASZ-1:0] m2w_Rd_addr,
    output logic [RSZ-1:0]     m2w_Rd_data
);

    if (RSZ != 32) begin : g_badRsz
        $fatal(1, "m2w_xmit: RSZ must be 32");
    end
    if (GPR_ASZ != 5 && GPR_ASZ != 4) begin : g_badAsz
        $fatal(1, "m2w_xmit: GPR_ASZ must be 4 or 5");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic               wr;
        logic [GPR_ASZ-1:0] addr;
        logic [RSZ-1:0]     data;
    } entry_t;

    state_t r_state;
    entry_t r_main;
    entry_t r_skid;

    logic       w_in;
    logic       w_out;
    logic [7:0] w_ldByte;
    logic [15:0] w_ldHalf;
    entry_t     w_fmt;

    // Ready depends only on registered occupancy, never on m2w_rdy.
    assign mem_rdy   = reset_in & ~cpu_halt & (r_state != FULL);
    assign m2w_valid = (r_state != EMPTY);
    assign w_in      = mem_valid & mem_rdy;
    assign w_out     = m2w_valid & m2w_rdy;

    assign m2w_Rd_wr   = r_main.wr;
    assign m2w_Rd_addr = r_main.addr;
    assign m2w_Rd_data = r_main.data;

    assign w_ldByte = mem_ld_data[8*mem_byte_off +: 8];
    assign w_ldHalf = mem_byte_off[1] ? mem_ld_data[31:16] : mem_ld_data[15:0];

    always_comb begin
        w_fmt      = '0;
        w_fmt.wr   = mem_Rd_wr & (mem_Rd_addr != '0);
        w_fmt.addr = mem_Rd_addr;
        w_fmt.data = mem_Rd_data;
        if (mem_is_ld) begin
            case (mem_ld_size)
                2'd0: w_fmt.data = mem_ld_unsigned ? {{(RSZ-8){1'b0}}, w_ldByte}
                                                   : {{(RSZ-8){w_ldByte[7]}}, w_ldByte};
                2'd1: w_fmt.data = mem_ld_unsigned ? {{(RSZ-16){1'b0}}, w_ldHalf}
                                                   : {{(RSZ-16){w_ldHalf[15]}}, w_ldHalf};
                default: w_fmt.data = mem_ld_data;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in) begin
                        r_main  <= w_fmt;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_in && w_out) begin
                        r_main <= w_fmt;
                    end else if (w_in) begin
                        r_skid  <= w_fmt;
                        r_state <= FULL;
                    end else if (w_out) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    // Skid is always older than anything new, so it refills main.
                    if (w_out) begin
                        r_main  <= r_skid;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_m2w_xmit.sv
// Self-checking bench for m2w_xmit: scoreboard of formatted results plus
// directed checks of ready/valid timing, halt and reset behaviour.
module tb_m2w_xmit;

    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        cpu_halt;
    logic        mem_valid;
    logic        mem_rdy;
    logic        mem_Rd_wr;
    logic [4:0]  mem_Rd_addr;
    logic [31:0] mem_Rd_data;
    logic        mem_is_ld;
    logic [1:0]  mem_ld_size;
    logic        mem_ld_unsigned;
    logic [1:0]  mem_byte_off;
    logic [31:0] mem_ld_data;
    logic        m2w_valid;
    logic        m2w_rdy;
    logic        m2w_Rd_wr;
    logic [4:0]  m2w_Rd_addr;
    logic [31:0] m2w_Rd_data;

    int   vectorsApplied = 0;
    int   miscompares    = 0;
    exp_t sbQueue[$];

    m2w_xmit #(.RSZ(32), .GPR_ASZ(5)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .cpu_halt       (cpu_halt),
        .mem_valid      (mem_valid),
        .mem_rdy        (mem_rdy),
        .mem_Rd_wr      (mem_Rd_wr),
        .mem_Rd_addr    (mem_Rd_addr),
        .mem_Rd_data    (mem_Rd_data),
        .mem_is_ld      (mem_is_ld),
        .mem_ld_size    (mem_ld_size),
        .mem_ld_unsigned(mem_ld_unsigned),
        .mem_byte_off   (mem_byte_off),
        .mem_ld_data    (mem_ld_data),
        .m2w_valid      (m2w_valid),
        .m2w_rdy        (m2w_rdy),
        .m2w_Rd_wr      (m2w_Rd_wr),
        .m2w_Rd_addr    (m2w_Rd_addr),
        .m2w_Rd_data    (m2w_Rd_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic exp_t modelResult(input logic wr, input logic [4:0] addr,
                                         input logic [31:0] rdData, input logic isLd,
                                         input logic [1:0] size, input logic uns,
                                         input logic [1:0] off, input logic [31:0] ld);
        exp_t       e;
        logic [7:0] b;
        logic [15:0] h;
        e.wr   = wr && (addr != 5'd0);
        e.addr = addr;
        e.data = rdData;
        if (isLd) begin
            case (off)
                2'd0: b = ld[7:0];
                2'd1: b = ld[15:8];
                2'd2: b = ld[23:16];
                default: b = ld[31:24];
            endcase
            h = (off >= 2'd2) ? ld[31:16] : ld[15:0];
            if (size == 2'd0)      e.data = uns ? {24'h0, b} : {{24{b[7]}}, b};
            else if (size == 2'd1) e.data = uns ? {16'h0, h} : {{16{h[15]}}, h};
            else                   e.data = ld;
        end
        return e;
    endfunction

    // Transfers are decided by the levels seen here, just before the next rising edge.
    always @(negedge clk_in) begin
        exp_t e;
        if (!reset_in) begin
            sbQueue.delete();
        end else begin
            if (m2w_valid && m2w_rdy) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("sbUnexpectedOut", 32'd1, 32'd0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("outWr",   {31'd0, m2w_Rd_wr}, {31'd0, e.wr});
                    checkOutput("outAddr", {27'd0, m2w_Rd_addr}, {27'd0, e.addr});
                    checkOutput("outData", m2w_Rd_data, e.data);
                end
            end
            if (mem_valid && mem_rdy) begin
                sbQueue.push_back(modelResult(mem_Rd_wr, mem_Rd_addr, mem_Rd_data, mem_is_ld,
                                              mem_ld_size, mem_ld_unsigned, mem_byte_off,
                                              mem_ld_data));
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic wr, input logic [4:0] addr,
                                 input logic [31:0] rdData, input logic isLd,
                                 input logic [1:0] size, input logic uns,
                                 input logic [1:0] off, input logic [31:0] ld);
        mem_valid       = v;
        mem_Rd_wr       = wr;
        mem_Rd_addr     = addr;
        mem_Rd_data     = rdData;
        mem_is_ld       = isLd;
        mem_ld_size     = size;
        mem_ld_unsigned = uns;
        mem_byte_off    = off;
        mem_ld_data     = ld;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic offerAlu(input logic [4:0] addr, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, addr, d, 1'b0, 2'd0, 1'b0, 2'd0, 32'hA5A5_A5A5);
    endtask

    task automatic checkOut(input string tag, input logic v, input logic [4:0] addr,
                            input logic [31:0] d);
        checkOutput({tag, "_valid"}, {31'd0, m2w_valid}, {31'd0, v});
        checkOutput({tag, "_addr"}, {27'd0, m2w_Rd_addr}, {27'd0, addr});
        checkOutput({tag, "_data"}, m2w_Rd_data, d);
    endtask

    initial begin
        int waitCycles;
        reset_in = 1'b0;
        cpu_halt = 1'b0;
        m2w_rdy  = 1'b0;
        idle();
        tick();
        tick();
        checkOut("reset", 1'b0, 5'd0, 32'd0);
        checkOutput("reset_wr", {31'd0, m2w_Rd_wr}, 32'd0);
        checkOutput("reset_memRdy", {31'd0, mem_rdy}, 32'd0);
        reset_in = 1'b1;
        #1;
        checkOutput("postReset_memRdy", {31'd0, mem_rdy}, 32'd1);

        // Single ALU result, one-cycle latency, valid drops after transfer.
        m2w_rdy = 1'b1;
        offerAlu(5'd5, 32'h1234_5678);
        tick();
        idle();
        checkOut("single", 1'b1, 5'd5, 32'h1234_5678);
        checkOutput("single_wr", {31'd0, m2w_Rd_wr}, 32'd1);
        tick();
        checkOutput("single_drop", {31'd0, m2w_valid}, 32'd0);

        // Load formatting, back to back.
        applyStimulus(1'b1, 1'b1, 5'd1, 32'd0, 1'b1, 2'd0, 1'b0, 2'd1, 32'h80FF_7F01);
        tick();
        checkOutput("ldByteOff1", m2w_Rd_data, 32'h0000_007F);
        applyStimulus(1'b1, 1'b1, 5'd2, 32'd0, 1'b1, 2'd0, 1'b0, 2'd3, 32'h80FF_7F01);
        tick();
        checkOutput("ldByteOff3", m2w_Rd_data, 32'hFFFF_FF80);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'd0, 1'b1, 2'd1, 1'b1, 2'd2, 32'h80FF_7F01);
        tick();
        checkOutput("ldHalfOff2", m2w_Rd_data, 32'h0000_80FF);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'd0, 1'b1, 2'd2, 1'b0, 2'd3, 32'h80FF_7F01);
        tick();
        checkOutput("ldWord", m2w_Rd_data, 32'h80FF_7F01);
        idle();
        tick();

        // Backpressure: fill to FULL, then drain three in order.
        m2w_rdy = 1'b0;
        offerAlu(5'd10, 32'hAAAA_0001);
        tick();
        offerAlu(5'd11, 32'hAAAA_0002);
        tick();
        checkOutput("bp_fullRdy", {31'd0, mem_rdy}, 32'd0);
        offerAlu(5'd12, 32'hAAAA_0003);
        tick();
        checkOutput("bp_heldRdy", {31'd0, mem_rdy}, 32'd0);
        checkOut("bp_held", 1'b1, 5'd10, 32'hAAAA_0001);
        m2w_rdy = 1'b1;
        tick();
        checkOutput("bp_rdyBack", {31'd0, mem_rdy}, 32'd1);
        checkOut("bp_second", 1'b1, 5'd11, 32'hAAAA_0002);
        tick();
        idle();
        checkOut("bp_third", 1'b1, 5'd12, 32'hAAAA_0003);
        tick();
        checkOutput("bp_empty", {31'd0, m2w_valid}, 32'd0);

        // Write to x0 keeps address/data but clears Rd_wr.
        offerAlu(5'd0, 32'hDEAD_BEEF);
        tick();
        idle();
        checkOutput("x0_wr", {31'd0, m2w_Rd_wr}, 32'd0);
        checkOut("x0", 1'b1, 5'd0, 32'hDEAD_BEEF);
        tick();

        // Halt with a full buffer.
        m2w_rdy = 1'b0;
        offerAlu(5'd20, 32'h2020_2020);
        tick();
        offerAlu(5'd21, 32'h2121_2121);
        tick();
        idle();
        cpu_halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offerAlu(5'd22, 32'h2222_2222);
            tick();
            checkOutput("halt_memRdy", {31'd0, mem_rdy}, 32'd0);
            checkOut("halt_hold", 1'b1, 5'd20, 32'h2020_2020);
        end
        idle();
        cpu_halt = 1'b0;
        m2w_rdy  = 1'b1;
        tick();
        checkOut("halt_drain", 1'b1, 5'd21, 32'h2121_2121);
        tick();
        checkOutput("halt_empty", {31'd0, m2w_valid}, 32'd0);

        // Reset while full.
        m2w_rdy = 1'b0;
        offerAlu(5'd25, 32'h2525_2525);
        tick();
        offerAlu(5'd26, 32'h2626_2626);
        tick();
        idle();
        reset_in = 1'b0;
        tick();
        checkOut("midReset", 1'b0, 5'd0, 32'd0);
        checkOutput("midReset_wr", {31'd0, m2w_Rd_wr}, 32'd0);
        checkOutput("midReset_memRdy", {31'd0, mem_rdy}, 32'd0);
        reset_in = 1'b1;
        #1;
        checkOutput("afterReset_memRdy", {31'd0, mem_rdy}, 32'd1);

        // Random traffic checked purely by the scoreboard.
        for (int i = 0; i < 300; i++) begin
            m2w_rdy = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 2) != 0, 1'($urandom), 5'($urandom),
                          $urandom, 1'($urandom), 2'($urandom), 1'($urandom),
                          2'($urandom), $urandom);
            tick();
        end
        idle();
        m2w_rdy    = 1'b1;
        waitCycles = 0;
        while ((sbQueue.size() != 0 || m2w_valid) && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        checkOutput("drainTimeout", (waitCycles < 20) ? 32'd0 : 32'd1, 32'd0);
        checkOutput("finalQueue", sbQueue.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
